seg_scan_capture: RTL and testbench
===================================

// Module: seg_scan_capture
// PURPOSE
//  Reads back a multiplexed, active-low 4-digit seven-segment display bus and recovers the hex digits shown.
//  Inverse of the hex-to-segment drivers: sits on the segment and anode pins of the score and lives display.
//  Used for self-check and for the debug readout path.
//  Qualifies each strobed digit for stability, decodes the glyph to a nibble and flags unknown glyphs.
// PARAMETERS
//  STABLE_CYC   4        consecutive identical samples required to accept a digit (>=1)
//  TIMEOUT_CYC  1000000  cycles with no capture before all digits are invalidated (0 = disabled)
//  TO_W         20       width of the timeout counter (must hold TIMEOUT_CYC)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous reset, active-high
//  seg_n      in   7   segments, active-low: [0]=a top, [1]=b up-right, [2]=c low-right,
//                      [3]=d bottom, [4]=e low-left, [5]=f up-left, [6]=g middle
//  an_n       in   4   digit strobes, active-low, one-hot; an_n[i] selects digit i
//  hex_out    out  16  digit i is at [4i+3:4i]
//  valid      out  4   digit i holds a decoded glyph
//  err        out  4   last glyph seen on digit i was not in the table
//  frame_done out  1   one-cycle pulse when all 4 digits have been captured since the last pulse
//  timeout    out  1   high while the timeout has expired and no capture has occurred since
// BEHAVIOUR
//  - Clock and reset: one clock; reset is asynchronous and active-high.
//  - Reset values: hex_out=0, valid=0, err=0, frame_done=0, timeout=0. All counters, sync flops and flags are cleared.
//  - Synchroniser: seg_n and an_n pass through 2 flops. All rules below apply to the synchronised samples (S).
//  - Legal strobe: exactly one bit of an_n is low.
//    Zero bits low or more than one bit low is idle: the stability counter resets and nothing is captured.
//  - Stability: stab_cnt increments when S equals the previous S and the strobe is legal; any change resets it to 0.
//    A capture fires once, on the edge that takes the STABLE_CYC-th identical sample.
//    After that it is armed again only after S changes.
//    Latency from pins settling to the output update is STABLE_CYC+2 cycles.
//  - Decode uses p = ~seg_n, read as gfedcba:
//    0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=67 A=77 b=7C C=39 d=5E E=79 F=71.
//  - Capture on digit i:
//    known glyph -> hex nibble i = value, valid[i]=1, err[i]=0.
//    blank (p=00) -> valid[i]=0, err[i]=0, nibble held.
//    any other p -> valid[i]=0, err[i]=1, nibble held.
//  - Frame: seen[i] sets on any capture of digit i.
//    On the cycle seen would become 1111, frame_done=1 and seen clears to 0000 in that same cycle.
//    Recapturing a digit already in seen has no extra effect.
//  - Timeout: to_cnt resets on every capture and otherwise increments, saturating.
//    When to_cnt reaches TIMEOUT_CYC: valid=0000, seen=0000, timeout=1. hex_out and err are held.
//    The next capture clears timeout and updates normally.
//    If a capture and the expiry fall in the same cycle, the capture wins.
//  - Reset mid-operation: everything returns to reset values immediately. No partial capture survives.
// CONFIGURATION
//  - SEG_ALT_GLYPH_EN defined: two extra entries are also decoded as valid: p=6F -> 9, p=27 -> 7.
//  - Not defined: 6F and 27 are unknown glyphs and set err.
// TESTING
//  1. Reset, then hold an_n=1110, p=4F for 10 cycles.
//     -> hex_out[3:0]=3 and valid=0001 at cycle 6 after settling. No further update while held.
//  2. Scan digits 0..3 with p=06,77,67,71, 8 cycles each.
//     -> hex_out=F9A1, valid=1111.
//     -> exactly one frame_done pulse, on the cycle digit 3 is captured.
//  3. Hold p=5B on digit 2 for 3 cycles, then change it; also assert rst mid-count.
//     -> no capture; after reset all outputs are 0.
//  4. Drive p=49 on digit 1 after a valid 5.
//     -> err=0010, valid[1]=0, hex nibble 1 stays 5.
//  5. Bench uses TIMEOUT_CYC=50. Capture 4 digits, then hold an_n=1111 for 50 cycles.
//     -> valid=0000 and timeout=1. The next capture clears timeout.
//  6. Drive p=6F on digit 0.
//     -> with SEG_ALT_GLYPH_EN: nibble 0 = 9, valid[0]=1.
//     -> without it: err[0]=1, valid[0]=0.

Source files
------------

// File: rtl/seg_scan_capture_if.sv
// seg_scan_capture_if: pin/readout bundle for the seven-segment scan capture block.
//   seg_n[6:0]  active-low segments (a..g in bits 0..6), driven by the display side
//   an_n[3:0]   active-low one-hot digit strobes
//   hex_out     recovered digits, digit i at [4i+3:4i]
//   valid/err   per-digit decode status
//   frame_done  one-cycle pulse when all four digits have been captured
//   timeout     no capture for the configured time
// master = the side driving the pins and reading results; slave = the capture block.
interface seg_scan_capture_if;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] hex_out;
  logic [3:0]  valid;
  logic [3:0]  err;
  logic        frame_done;
  logic        timeout;

  modport master (
    output seg_n, an_n,
    input  hex_out, valid, err, frame_done, timeout
  );

  modport slave (
    input  seg_n, an_n,
    output hex_out, valid, err, frame_done, timeout
  );
endinterface

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: reads back a multiplexed active-low 4-digit seven-segment bus
// and recovers the hex digits shown. Each strobed digit is qualified for stability,
// decoded from its glyph to a nibble, and unknown glyphs are flagged.
// Ports:
//   clk   system clock
//   rst   asynchronous reset, active-high
//   bus   seg_scan_capture_if.slave (seg_n/an_n in; hex_out/valid/err/frame_done/timeout out)
// Parameters: STABLE_CYC (identical samples to accept), TIMEOUT_CYC (0 = off), TO_W.
// Optional feature: define SEG_ALT_GLYPH_EN to also accept the alternate 9 (6F) and 7 (27) glyphs.
module seg_scan_capture #(
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter int unsigned TO_W        = 20
) (
  input  logic               clk,
  input  logic               rst,
  seg_scan_capture_if.slave  bus
);

  localparam int unsigned SC_W = $clog2(STABLE_CYC + 1);

  logic [6:0]      seg_s1, seg_s2;
  logic [3:0]      an_s1, an_s2;
  logic [SC_W-1:0] stab_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [15:0]     hex_q;
  logic [3:0]      valid_q, err_q, seen_q;
  logic            frame_q, timeout_q;

  logic       legal_c, same_c, capture_c, expire_c, known_c;
  logic [1:0] dig_c;
  logic [3:0] nib_c, seen_nxt_c;
  logic [6:0] p_c;

  // Two-flop synchroniser on the pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1 <= '0;
      seg_s2 <= '0;
      an_s1  <= '0;
      an_s2  <= '0;
    end else begin
      seg_s1 <= bus.seg_n;
      seg_s2 <= seg_s1;
      an_s1  <= bus.an_n;
      an_s2  <= an_s1;
    end
  end

  // Strobe legality, stability and glyph decode of the incoming sample
  always_comb begin
    legal_c = 1'b1;
    dig_c   = 2'd0;
    case (an_s1)
      4'b1110: dig_c = 2'd0;
      4'b1101: dig_c = 2'd1;
      4'b1011: dig_c = 2'd2;
      4'b0111: dig_c = 2'd3;
      default: legal_c = 1'b0;
    endcase
    // The sample entering the last stage is compared with the one already there
    same_c    = legal_c && (seg_s1 == seg_s2) && (an_s1 == an_s2);
    capture_c = same_c && (stab_cnt == SC_W'(STABLE_CYC - 1));
    expire_c  = (TIMEOUT_CYC != 0) && !capture_c && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    p_c     = ~seg_s1;
    known_c = 1'b1;
    nib_c   = 4'h0;
    case (p_c)
      7'h3F: nib_c = 4'h0;
      7'h06: nib_c = 4'h1;
      7'h5B: nib_c = 4'h2;
      7'h4F: nib_c = 4'h3;
      7'h66: nib_c = 4'h4;
      7'h6D: nib_c = 4'h5;
      7'h7D: nib_c = 4'h6;
      7'h07: nib_c = 4'h7;
      7'h7F: nib_c = 4'h8;
      7'h67: nib_c = 4'h9;
      7'h77: nib_c = 4'hA;
      7'h7C: nib_c = 4'hB;
      7'h39: nib_c = 4'hC;
      7'h5E: nib_c = 4'hD;
      7'h79: nib_c = 4'hE;
      7'h71: nib_c = 4'hF;
`ifdef SEG_ALT_GLYPH_EN
      7'h6F: nib_c = 4'h9;
      7'h27: nib_c = 4'h7;
`endif
      default: known_c = 1'b0;
    endcase

    seen_nxt_c = seen_q | (4'b0001 << dig_c);
  end

  // Stability counter saturates so a held digit captures only once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_cnt <= '0;
    end else if (!same_c) begin
      stab_cnt <= '0;
    end else if (stab_cnt != SC_W'(STABLE_CYC)) begin
      stab_cnt <= stab_cnt + SC_W'(1);
    end
  end

  // Capture, frame tracking and timeout; a capture beats a same-cycle expiry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt    <= '0;
      hex_q     <= '0;
      valid_q   <= '0;
      err_q     <= '0;
      seen_q    <= '0;
      frame_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      if (capture_c) begin
        to_cnt    <= '0;
        timeout_q <= 1'b0;
        if (known_c) begin
          hex_q[{dig_c, 2'b00} +: 4] <= nib_c;
          valid_q[dig_c]             <= 1'b1;
          err_q[dig_c]               <= 1'b0;
        end else begin
          valid_q[dig_c] <= 1'b0;
          err_q[dig_c]   <= (p_c != 7'h00);
        end
        if (seen_nxt_c == 4'hF) begin
          frame_q <= 1'b1;
          seen_q  <= '0;
        end else begin
          seen_q <= seen_nxt_c;
        end
      end else begin
        if (to_cnt != TO_W'(TIMEOUT_CYC)) to_cnt <= to_cnt + TO_W'(1);
        if (expire_c) begin
          valid_q   <= '0;
          seen_q    <= '0;
          timeout_q <= 1'b1;
        end
      end
    end
  end

  assign bus.hex_out    = hex_q;
  assign bus.valid      = valid_q;
  assign bus.err        = err_q;
  assign bus.frame_done = frame_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed scenarios plus random scanning, compared every cycle
// against a window-based reference model of the capture rules.
module tb_seg_scan_capture;

  localparam int unsigned SC = 4;
  localparam int unsigned TO = 50;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seg_scan_capture_if bus ();

  seg_scan_capture #(.STABLE_CYC(SC), .TIMEOUT_CYC(TO), .TO_W(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int frame_cnt = 0;
  int frame_cyc = 0;

  // Reference state: pin history (newest first) and the visible results
  logic [10:0] hist [SC+3];
  logic [15:0] m_hex;
  logic [3:0]  m_valid, m_err, m_seen;
  logic        m_frame, m_to;
  int          m_since;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SC + 3; i++) hist[i] = '0;
    m_hex = '0; m_valid = '0; m_err = '0; m_seen = '0;
    m_frame = 1'b0; m_to = 1'b0; m_since = 0;
  endtask

  task automatic decode(input logic [6:0] p, output logic known, output logic [3:0] v);
    known = 1'b0;
    v = 4'h0;
    for (int i = 0; i < 16; i++)
      if (GLYPH[i] == p) begin known = 1'b1; v = 4'(i); end
`ifdef SEG_ALT_GLYPH_EN
    if (p == 7'h6F) begin known = 1'b1; v = 4'h9; end
    if (p == 7'h27) begin known = 1'b1; v = 4'h7; end
`endif
  endtask

  // One clock edge: a digit is taken when the last SC+1 synchronised samples agree
  // on a legal strobe and the sample before that run differed.
  task automatic model_edge(input logic [10:0] pins);
    logic fire, known;
    logic [3:0] an, v;
    logic [6:0] p;
    int d;
    for (int i = SC + 2; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = pins;
    an = hist[1][10:7];
    p  = ~hist[1][6:0];
    fire = ($countones(~an) == 1);
    for (int i = 2; i <= SC + 1; i++) if (hist[i] != hist[1]) fire = 1'b0;
    if (hist[SC+2] == hist[1]) fire = 1'b0;
    d = 0;
    for (int i = 0; i < 4; i++) if (!an[i]) d = i;
    m_frame = 1'b0;
    if (fire) begin
      m_since = 0;
      m_to = 1'b0;
      decode(p, known, v);
      if (known) begin
        m_hex[4*d +: 4] = v;
        m_valid[d] = 1'b1;
        m_err[d] = 1'b0;
      end else begin
        m_valid[d] = 1'b0;
        m_err[d] = (p != 7'h00);
      end
      m_seen[d] = 1'b1;
      if (m_seen == 4'hF) begin
        m_frame = 1'b1;
        m_seen = 4'h0;
      end
    end else if (m_since < int'(TO)) begin
      m_since++;
      if (m_since == int'(TO)) begin
        m_valid = 4'h0;
        m_seen = 4'h0;
        m_to = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge({bus.an_n, bus.seg_n});
    #1;
    cyc++;
    check("hex_out", 32'(bus.hex_out), 32'(m_hex));
    check("valid", 32'(bus.valid), 32'(m_valid));
    check("err", 32'(bus.err), 32'(m_err));
    check("frame_done", 32'(bus.frame_done), 32'(m_frame));
    check("timeout", 32'(bus.timeout), 32'(m_to));
    if (bus.frame_done) begin
      frame_cnt++;
      frame_cyc = cyc;
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] p, input int n);
    bus.an_n = an;
    bus.seg_n = ~p;
    repeat (n) step();
  endtask

  // Asynchronous reset from wherever we are; outputs must clear immediately
  task automatic reset_now();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_hex", 32'(bus.hex_out), 32'h0);
    check("rst_valid", 32'(bus.valid), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    check("rst_frame", 32'(bus.frame_done), 32'h0);
    check("rst_timeout", 32'(bus.timeout), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] an;
    logic [6:0] p;
    int r;
    bus.an_n = 4'hF;
    bus.seg_n = 7'h7F;
    #2;
    reset_now();

    // Held digit 0 showing 3: appears on the 6th edge, then no further change
    bus.an_n = 4'b1110;
    bus.seg_n = ~7'h4F;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 5) check("t1_early_valid", 32'(bus.valid), 32'h0);
      if (i >= 6) begin
        check("t1_nib0", 32'(bus.hex_out[3:0]), 32'h3);
        check("t1_valid", 32'(bus.valid), 32'h1);
      end
    end

    // Full scan: one frame pulse, on the edge digit 3 is captured
    cyc = 0;
    frame_cnt = 0;
    drive(4'b1110, 7'h06, 8);
    drive(4'b1101, 7'h77, 8);
    drive(4'b1011, 7'h67, 8);
    drive(4'b0111, 7'h71, 8);
    check("t2_hex", 32'(bus.hex_out), 32'hF9A1);
    check("t2_valid", 32'(bus.valid), 32'hF);
    check("t2_frames", 32'(frame_cnt), 32'd1);
    check("t2_frame_cyc", 32'(frame_cyc), 32'd30);

    // Too-short holds never capture; reset mid-count clears everything
    drive(4'b1011, 7'h5B, 3);
    drive(4'b1011, 7'h4F, 3);
    check("t3_hex", 32'(bus.hex_out), 32'hF9A1);
    check("t3_valid", 32'(bus.valid), 32'hF);
    reset_now();

    // Unknown glyph after a valid 5 on digit 1
    drive(4'b1101, 7'h6D, 8);
    check("t4_nib1", 32'(bus.hex_out[7:4]), 32'h5);
    check("t4_valid", 32'(bus.valid), 32'h2);
    drive(4'b1101, 7'h49, 8);
    check("t4_err", 32'(bus.err), 32'h2);
    check("t4_valid1", 32'(bus.valid[1]), 32'h0);
    check("t4_nib1_held", 32'(bus.hex_out[7:4]), 32'h5);

    // Timeout after an idle stretch, cleared by the next capture
    drive(4'b1110, 7'h3F, 8);
    drive(4'b1101, 7'h5B, 8);
    drive(4'b1011, 7'h4F, 8);
    drive(4'b0111, 7'h66, 8);
    check("t5_valid_pre", 32'(bus.valid), 32'hF);
    check("t5_to_pre", 32'(bus.timeout), 32'h0);
    drive(4'b1111, 7'h00, 50);
    check("t5_valid_to", 32'(bus.valid), 32'h0);
    check("t5_to", 32'(bus.timeout), 32'h1);
    check("t5_hex_held", 32'(bus.hex_out), 32'h4320);
    drive(4'b1110, 7'h3F, 8);
    check("t5_to_clear", 32'(bus.timeout), 32'h0);
    check("t5_valid_post", 32'(bus.valid), 32'h1);

    // Alternate 9 glyph on digit 0
    drive(4'b1110, 7'h6F, 8);
`ifdef SEG_ALT_GLYPH_EN
    check("t6_nib0", 32'(bus.hex_out[3:0]), 32'h9);
    check("t6_valid0", 32'(bus.valid[0]), 32'h1);
`else
    check("t6_err0", 32'(bus.err[0]), 32'h1);
    check("t6_valid0", 32'(bus.valid[0]), 32'h0);
`endif

    // Random scanning with glitches, idle and illegal strobes
    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      an = 4'(~(4'b0001 << $urandom_range(0, 3)));
      else if (r < 85) an = 4'hF;
      else             an = 4'($urandom);
      if ($urandom_range(0, 3) != 0) p = GLYPH[$urandom_range(0, 15)];
      else                           p = 7'($urandom);
      drive(an, p, int'($urandom_range(1, 9)));
      if (k % 100 == 99) drive(4'hF, 7'h00, 60);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
